// File: rtl/fetch_unit_if.sv
// Interface between the fetch stage and its neighbours: instruction ROM,
// execute redirect path, and the decode valid/ready output channel.
// master = fetch_unit side, slave = environment (ROM / execute / decode).
interface fetch_unit_if #(
  parameter int IWIDTH = 16,
  parameter int AWIDTH = 8
);
  // ROM port
  logic [AWIDTH-1:0] rom_addr;
  logic [IWIDTH-1:0] rom_data;
  // Redirect from execute
  logic              redirect_valid;
  logic [AWIDTH-1:0] redirect_pc;
  // Output channel to decode
  logic              out_valid;
  logic              out_ready;
  logic [IWIDTH-1:0] out_instr;
  logic [AWIDTH-1:0] out_pc;
  logic              halted;

  modport master (
    output rom_addr,
    input  rom_data,
    input  redirect_valid,
    input  redirect_pc,
    output out_valid,
    input  out_ready,
    output out_instr,
    output out_pc,
    output halted
  );

  modport slave (
    input  rom_addr,
    output rom_data,
    output redirect_valid,
    output redirect_pc,
    input  out_valid,
    output out_ready,
    input  out_instr,
    input  out_pc,
    input  halted
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage for the Mini-CPU.
// Owns the PC, addresses a combinational ROM and registers the returned word
// plus its PC into a one-entry output register drained by decode through a
// valid/ready handshake. Redirects flush and restart; a HALT opcode stops
// fetching until the next redirect or reset.
// Optional build macro FETCH_PERF_EN adds saturating transfer/stall counters.
module fetch_unit #(
  parameter int               IWIDTH   = 16,
  parameter int               AWIDTH   = 8,
  parameter logic [AWIDTH-1:0] RESET_PC = 8'h00,
  parameter logic [7:0]        HALT_OP  = 8'h0E
) (
  input  logic                clk,
  input  logic                rst_n,
  fetch_unit_if.master        bus
`ifdef FETCH_PERF_EN
  ,
  output logic [15:0]         perf_fetched,
  output logic [15:0]         perf_stalls
`endif
);

  typedef enum logic {
    S_RUN    = 1'b0,
    S_HALTED = 1'b1
  } state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic [AWIDTH-1:0] r_pc;
  logic              r_out_valid;
  logic [IWIDTH-1:0] r_out_instr;
  logic [AWIDTH-1:0] r_out_pc;

  logic              w_capture;
  logic              w_is_halt;

  // The output register can take a new word when it is empty or being drained
  // this cycle; a redirect always wins and suppresses the capture.
  assign w_capture = (r_state == S_RUN) && (!r_out_valid || bus.out_ready)
                     && !bus.redirect_valid;
  assign w_is_halt = (bus.rom_data[IWIDTH-1 -: 8] == HALT_OP);

  // Next-state logic: redirect resumes RUN, capturing a HALT word stops fetch.
  always_comb begin
    // NOTE: default assigned first so every path drives the signal; otherwise
    // a latch is inferred.
    w_state_next = r_state;
    if (bus.redirect_valid) begin
      w_state_next = S_RUN;
    end else if (w_capture && w_is_halt) begin
      w_state_next = S_HALTED;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_RUN;
    end else begin
      // NOTE: non-blocking assignments for all clocked state so every register
      // samples pre-edge values regardless of statement order.
      r_state <= w_state_next;
    end
  end

  // PC and output register: flush on redirect, capture, or bubble on drain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc        <= RESET_PC;
      r_out_valid <= 1'b0;
      r_out_instr <= '0;
      r_out_pc    <= '0;
    end else if (bus.redirect_valid) begin
      r_pc        <= bus.redirect_pc;
      r_out_valid <= 1'b0;
    end else if (w_capture) begin
      r_out_instr <= bus.rom_data;
      r_out_pc    <= r_pc;
      r_out_valid <= 1'b1;
      r_pc        <= r_pc + AWIDTH'(1);
    end else if (bus.out_ready) begin
      // Not capturing while decode is ready: either the halted stage drains
      // its last word or nothing was held; either way the register empties.
      r_out_valid <= 1'b0;
    end
  end

  assign bus.rom_addr  = r_pc;
  assign bus.out_valid = r_out_valid;
  assign bus.out_instr = r_out_instr;
  assign bus.out_pc    = r_out_pc;
  assign bus.halted    = (r_state == S_HALTED);

`ifdef FETCH_PERF_EN
  logic [15:0] r_perf_fetched;
  logic [15:0] r_perf_stalls;

  // Saturating counters of transfers and stall cycles; redirects leave them alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perf_fetched <= '0;
      r_perf_stalls  <= '0;
    end else if (r_out_valid) begin
      if (bus.out_ready) begin
        if (r_perf_fetched != 16'hFFFF) r_perf_fetched <= r_perf_fetched + 16'd1;
      end else begin
        if (r_perf_stalls != 16'hFFFF) r_perf_stalls <= r_perf_stalls + 16'd1;
      end
    end
  end

  assign perf_fetched = r_perf_fetched;
  assign perf_stalls  = r_perf_stalls;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed testbench for fetch_unit. Inputs are driven and outputs sampled on
// the falling clock edge, away from the active rising edge.
module tb_fetch_unit;

  localparam int IWIDTH = 16;
  localparam int AWIDTH = 8;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  logic [IWIDTH-1:0] rom [0:255];

  fetch_unit_if #(.IWIDTH(IWIDTH), .AWIDTH(AWIDTH)) bus ();

`ifdef FETCH_PERF_EN
  logic [15:0] perf_fetched;
  logic [15:0] perf_stalls;
`endif

  fetch_unit #(
    .IWIDTH  (IWIDTH),
    .AWIDTH  (AWIDTH),
    .RESET_PC(8'h00),
    .HALT_OP (8'h0E)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.master)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetched(perf_fetched),
    .perf_stalls (perf_stalls)
`endif
  );

  // Combinational ROM model.
  assign bus.rom_data = rom[bus.rom_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  // {out_valid, out_pc, out_instr} packed for compact comparison.
  function automatic logic [24:0] out_word();
    return {bus.out_valid, bus.out_pc, bus.out_instr};
  endfunction

  task automatic redirect_to(input logic [7:0] pc);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = pc;
    @(negedge clk);
    bus.redirect_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n              = 1'b0;
    bus.out_ready      = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 8'h00;
    #12;
    n_checks++;
    if (out_word() !== 25'h0) begin
      n_fail++;
      $display("FAIL reset_out: got %h expected %h", out_word(), 25'h0);
    end
    n_checks++;
    if ({bus.rom_addr, bus.halted} !== {8'h00, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_pc_halted: got %h/%b expected 00/0", bus.rom_addr, bus.halted);
    end
`ifdef FETCH_PERF_EN
    n_checks++;
    if ({perf_fetched, perf_stalls} !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_perf: got %h/%h expected 0/0", perf_fetched, perf_stalls);
    end
`endif
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_stream();
    logic [15:0] exp_instr [3];
    exp_instr = '{16'h1300, 16'h1003, 16'h1004};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if (out_word() !== {1'b1, 8'(i), exp_instr[i]}) begin
        n_fail++;
        $display("FAIL stream_%0d: got %h expected %h", i, out_word(), {1'b1, 8'(i), exp_instr[i]});
      end
    end
  endtask

  task automatic test_stall();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    @(negedge clk);                 // 00/1300 presented
    @(negedge clk);                 // 01/1003 presented
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if ({out_word(), bus.rom_addr} !== {1'b1, 8'h01, 16'h1003, 8'h02}) begin
        n_fail++;
        $display("FAIL stall_hold_%0d: got %h/%h expected %h/02", i, out_word(), bus.rom_addr,
                 {1'b1, 8'h01, 16'h1003});
      end
    end
`ifdef FETCH_PERF_EN
    n_checks++;
    if ({perf_fetched, perf_stalls} !== {16'd1, 16'd3}) begin
      n_fail++;
      $display("FAIL stall_perf: got %0d/%0d expected 1/3", perf_fetched, perf_stalls);
    end
`endif
    bus.out_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if (out_word() !== {1'b1, 8'h02, 16'h1004}) begin
      n_fail++;
      $display("FAIL stall_resume: got %h expected %h", out_word(), {1'b1, 8'h02, 16'h1004});
    end
  endtask

  task automatic test_redirect_stall();
    bus.out_ready = 1'b0;
    @(negedge clk);
    n_checks++;
    if (out_word() !== {1'b1, 8'h02, 16'h1004}) begin
      n_fail++;
      $display("FAIL redir_stall_hold: got %h expected %h", out_word(), {1'b1, 8'h02, 16'h1004});
    end
    redirect_to(8'h26);
    n_checks++;
    if ({bus.out_valid, bus.rom_addr} !== {1'b0, 8'h26}) begin
      n_fail++;
      $display("FAIL redir_flush: got %b/%h expected 0/26", bus.out_valid, bus.rom_addr);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if (out_word() !== {1'b1, 8'h26, 16'h2026}) begin
      n_fail++;
      $display("FAIL redir_first: got %h expected %h", out_word(), {1'b1, 8'h26, 16'h2026});
    end
  endtask

  task automatic test_halt();
    logic [15:0] exp_instr [3];
    exp_instr = '{16'h2023, 16'h2024, 16'h0E00};
    bus.out_ready = 1'b1;
    redirect_to(8'h23);
    n_checks++;
    if (bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL halt_flush: got %b expected 0", bus.out_valid);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if ({out_word(), bus.halted} !== {1'b1, 8'(8'h23 + i), exp_instr[i], (i == 2)}) begin
        n_fail++;
        $display("FAIL halt_seq_%0d: got %h/%b expected %h/%b", i, out_word(), bus.halted,
                 {1'b1, 8'(8'h23 + i), exp_instr[i]}, (i == 2));
      end
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_checks++;
      if ({bus.out_valid, bus.halted, bus.rom_addr} !== {1'b0, 1'b1, 8'h26}) begin
        n_fail++;
        $display("FAIL halt_idle_%0d: valid/halted/addr got %b/%b/%h expected 0/1/26", i,
                 bus.out_valid, bus.halted, bus.rom_addr);
      end
    end
    redirect_to(8'h00);
    n_checks++;
    if ({bus.out_valid, bus.halted} !== 2'b00) begin
      n_fail++;
      $display("FAIL halt_exit: valid/halted got %b/%b expected 0/0", bus.out_valid, bus.halted);
    end
    @(negedge clk);
    n_checks++;
    if (out_word() !== {1'b1, 8'h00, 16'h1300}) begin
      n_fail++;
      $display("FAIL halt_resume: got %h expected %h", out_word(), {1'b1, 8'h00, 16'h1300});
    end
  endtask

  task automatic test_wrap();
    logic [7:0]  exp_pc    [3];
    logic [15:0] exp_instr [3];
    exp_pc    = '{8'hFF, 8'h00, 8'h01};
    exp_instr = '{16'h20FF, 16'h1300, 16'h1003};
    bus.out_ready = 1'b1;
    redirect_to(8'hFF);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if (out_word() !== {1'b1, exp_pc[i], exp_instr[i]}) begin
        n_fail++;
        $display("FAIL wrap_%0d: got %h expected %h", i, out_word(), {1'b1, exp_pc[i], exp_instr[i]});
      end
    end
  endtask

  task automatic test_back_to_back();
    bus.out_ready      = 1'b1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 8'h10;
    @(negedge clk);
    bus.redirect_pc    = 8'h30;
    @(negedge clk);
    bus.redirect_valid = 1'b0;
    n_checks++;
    if ({bus.out_valid, bus.rom_addr} !== {1'b0, 8'h30}) begin
      n_fail++;
      $display("FAIL b2b_flush: got %b/%h expected 0/30", bus.out_valid, bus.rom_addr);
    end
    @(negedge clk);
    n_checks++;
    if (out_word() !== {1'b1, 8'h30, 16'h2030}) begin
      n_fail++;
      $display("FAIL b2b_first: got %h expected %h", out_word(), {1'b1, 8'h30, 16'h2030});
    end
    // Redirect to the current pc (0x31): flush, no advance, refetch 0x31.
    redirect_to(8'h31);
    n_checks++;
    if ({bus.out_valid, bus.rom_addr} !== {1'b0, 8'h31}) begin
      n_fail++;
      $display("FAIL self_redir_flush: got %b/%h expected 0/31", bus.out_valid, bus.rom_addr);
    end
    @(negedge clk);
    n_checks++;
    if (out_word() !== {1'b1, 8'h31, 16'h2031}) begin
      n_fail++;
      $display("FAIL self_redir_first: got %h expected %h", out_word(), {1'b1, 8'h31, 16'h2031});
    end
  endtask

  task automatic test_async_reset();
    bus.out_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if (bus.out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL async_pre: valid got %b expected 1", bus.out_valid);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({out_word(), bus.rom_addr, bus.halted} !== {25'h0, 8'h00, 1'b0}) begin
      n_fail++;
      $display("FAIL async_reset: got %h/%h/%b expected 0/00/0", out_word(), bus.rom_addr, bus.halted);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (out_word() !== {1'b1, 8'h00, 16'h1300}) begin
      n_fail++;
      $display("FAIL async_restart: got %h expected %h", out_word(), {1'b1, 8'h00, 16'h1300});
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    for (int a = 0; a < 256; a++) rom[a] = {8'h20, 8'(a)};
    rom[8'h00] = 16'h1300;
    rom[8'h01] = 16'h1003;
    rom[8'h02] = 16'h1004;
    rom[8'h25] = 16'h0E00;

    test_reset();
    test_stream();
    test_stall();
    test_redirect_stall();
    test_halt();
    test_wrap();
    test_back_to_back();
    test_async_reset();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
